// File: rtl/j1_boot_loader.sv
// Boot sequencer for the j1 core: holds the CPU in reset, loads a framed image
// from a byte stream into code RAM, verifies an 8-bit sum, then releases the CPU.
module j1_boot_loader #(
  parameter int          AW            = 14,
  parameter logic [7:0]  MAGIC         = 8'hA5,
  parameter int          RELEASE_DELAY = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          boot_skip,
  input  logic          reload_req,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic          cpu_reset,
  output logic          done,
  output logic          err
);

  typedef enum logic [3:0] {
    S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM, S_HOLD, S_RUN, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'd1 << AW;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_len_lo;
  logic [15:0]     r_len;
  logic [7:0]      r_data_lo;
  logic [AW:0]     r_word_cnt;
  logic [7:0]      r_csum;
  logic [7:0]      r_hold_cnt;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [15:0]     r_wr_data;

  logic            w_in_ready;
  logic            w_accept;
  logic [16:0]     w_len;
  logic [AW:0]     w_cnt_inc;
  logic            w_last_word;

  assign w_accept    = in_valid & w_in_ready;
  assign w_len       = {1'b0, in_data, r_len_lo};
  assign w_cnt_inc   = r_word_cnt + 1'b1;
  assign w_last_word = (17'(w_cnt_inc) == 17'(r_len));

  // A pending reload blocks the byte so it is left for the restarted frame.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_SYNC:                                           w_in_ready = ~boot_skip;
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM: w_in_ready = ~reload_req;
      default:                                          w_in_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (reload_req && (r_state != S_SYNC)) begin
      w_state_next = S_SYNC;
    end else begin
      case (r_state)
        S_SYNC: begin
          if (boot_skip)                          w_state_next = S_HOLD;
          else if (w_accept && in_data == MAGIC)  w_state_next = S_LEN_LO;
        end
        S_LEN_LO:  if (w_accept) w_state_next = S_LEN_HI;
        S_LEN_HI: begin
          if (w_accept) begin
            if (w_len > MAX_LEN)      w_state_next = S_ERROR;
            else if (w_len == 17'd0)  w_state_next = S_CSUM;
            else                      w_state_next = S_DATA_LO;
          end
        end
        S_DATA_LO: if (w_accept) w_state_next = S_DATA_HI;
        S_DATA_HI: if (w_accept) w_state_next = w_last_word ? S_CSUM : S_DATA_LO;
        S_CSUM:    if (w_accept) w_state_next = (in_data == r_csum) ? S_HOLD : S_ERROR;
        S_HOLD:    if (r_hold_cnt == 8'(RELEASE_DELAY)) w_state_next = S_RUN;
        default:   w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_SYNC;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_lo   <= '0;
      r_len      <= '0;
      r_data_lo  <= '0;
      r_word_cnt <= '0;
      r_csum     <= '0;
      r_hold_cnt <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      // Counter is zero on HOLD entry; RUN is reached after RELEASE_DELAY+1 HOLD cycles.
      if (r_state != S_HOLD) r_hold_cnt <= '0;
      else                   r_hold_cnt <= r_hold_cnt + 8'd1;
      if (w_accept) begin
        case (r_state)
          S_SYNC: begin
            if (in_data == MAGIC) begin
              r_csum     <= '0;
              r_word_cnt <= '0;
            end
          end
          S_LEN_LO: begin
            r_len_lo <= in_data;
            r_csum   <= r_csum + in_data;
          end
          S_LEN_HI: begin
            r_len  <= {in_data, r_len_lo};
            r_csum <= r_csum + in_data;
          end
          S_DATA_LO: begin
            r_data_lo <= in_data;
            r_csum    <= r_csum + in_data;
          end
          S_DATA_HI: begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= r_word_cnt[AW-1:0];
            r_wr_data  <= {in_data, r_data_lo};
            r_word_cnt <= w_cnt_inc;
            r_csum     <= r_csum + in_data;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign cpu_reset = (r_state != S_RUN);
  assign done      = (r_state == S_RUN);
  assign err       = (r_state == S_ERROR);

endmodule

// File: tb/tb_j1_boot_loader.sv
// Directed bench for j1_boot_loader: frame loads, error paths, boot_skip,
// reload and mid-load reset, with hand-computed expected writes and timing.
module tb_j1_boot_loader;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          boot_skip = 1'b0;
  logic          reload_req = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          cpu_reset;
  logic          done;
  logic          err;

  j1_boot_loader #(.AW(AW), .MAGIC(8'hA5), .RELEASE_DELAY(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .boot_skip(boot_skip), .reload_req(reload_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wq_addr[$];
  logic [15:0] wq_data[$];
  int          wq_cyc[$];
  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] tx[$];
  int         hs_q[$];

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_byte(input logic [7:0] b, output int hs);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    hs = -1;
    n  = 0;
    while (hs < 0 && n < 50) begin
      @(negedge clk);
      if (in_ready) hs = cyc + 1;
      n++;
    end
    if (hs < 0) check("handshake_timeout", 32'(in_ready), 32'd1);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_seq();
    int hs;
    hs_q.delete();
    @(posedge clk);
    #1;
    foreach (tx[i]) begin
      send_byte(tx[i], hs);
      hs_q.push_back(hs);
      $display("tx byte %02h handshake edge %0d", tx[i], hs);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_release(output int fall);
    fall = -1;
    for (int n = 0; n < 60 && fall < 0; n++) begin
      @(negedge clk);
      if (!cpu_reset) fall = cyc;
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload_req = 1'b1;
    @(posedge clk);
    #1;
    reload_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_write(input string tag, input int idx, input int addr,
                             input logic [15:0] data, input int edge_no);
    if (idx < wq_addr.size()) begin
      check({tag, "_addr"}, 32'(wq_addr[idx]), 32'(addr));
      check({tag, "_data"}, 32'(wq_data[idx]), 32'(data));
      check({tag, "_lat"},  32'(wq_cyc[idx]),  32'(edge_no));
      $display("write %0d addr %0h data %04h at edge %0d", idx, wq_addr[idx], wq_data[idx], wq_cyc[idx]);
    end
  endtask

  initial begin
    int fall;
    int skip_edge;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_wr_en",     32'(wr_en),     32'd0);
    check("rst_wr_addr",   32'(wr_addr),   32'd0);
    check("rst_wr_data",   32'(wr_data),   32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    reset = 1'b0;

    // Two-word load
    clear_writes();
    tx = {8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
    send_seq();
    wait_release(fall);
    check("two_nwrites", 32'(wq_addr.size()), 32'd2);
    check_write("two_w0", 0, 0, 16'h1234, hs_q[4]);
    check_write("two_w1", 1, 1, 16'h5678, hs_q[6]);
    check("two_release", 32'(fall - hs_q[7]), 32'd5);
    check("two_done", 32'(done), 32'd1);
    check("two_err",  32'(err),  32'd0);
    check("two_in_ready", 32'(in_ready), 32'd0);
    do_reload();
    check("two_reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("two_reload_done", 32'(done), 32'd0);

    // Bad checksum
    clear_writes();
    tx = {8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB, 8'h00};
    send_seq();
    @(negedge clk);
    check("bad_err", 32'(err), 32'd1);
    check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("bad_in_ready", 32'(in_ready), 32'd0);
    repeat (6) @(negedge clk);
    check("bad_err_sticky", 32'(err), 32'd1);
    check("bad_nwrites", 32'(wq_addr.size()), 32'd1);
    check_write("bad_w0", 0, 0, 16'hABCD, hs_q[4]);
    do_reload();
    check("bad_reload_err", 32'(err), 32'd0);
    check("bad_reload_in_ready", 32'(in_ready), 32'd1);

    // Length overflow
    clear_writes();
    tx = {8'hA5, 8'h01, 8'h40};
    send_seq();
    @(negedge clk);
    check("ovf_err", 32'(err), 32'd1);
    repeat (6) @(negedge clk);
    check("ovf_nwrites", 32'(wq_addr.size()), 32'd0);
    do_reload();
    check("ovf_reload_err", 32'(err), 32'd0);

    // Garbage then zero-length frame
    clear_writes();
    tx = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_seq();
    wait_release(fall);
    check("zero_release", 32'(fall - hs_q[6]), 32'd5);
    check("zero_done", 32'(done), 32'd1);
    check("zero_nwrites", 32'(wq_addr.size()), 32'd0);
    do_reload();
    check("zero_reload_cpu_reset", 32'(cpu_reset), 32'd1);

    // boot_skip with a MAGIC byte presented
    clear_writes();
    @(posedge clk);
    #1;
    boot_skip = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    skip_edge = cyc + 1;
    @(negedge clk);
    check("skip_in_ready", 32'(in_ready), 32'd0);
    wait_release(fall);
    check("skip_release", 32'(fall - skip_edge), 32'd5);
    $display("boot_skip edge %0d release at %0d", skip_edge, fall);
    boot_skip = 1'b0;
    in_valid  = 1'b0;
    check("skip_done", 32'(done), 32'd1);
    check("skip_nwrites", 32'(wq_addr.size()), 32'd0);
    do_reload();
    check("skip_reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("skip_reload_in_ready", 32'(in_ready), 32'd1);

    // Reset after the first data low byte
    clear_writes();
    tx = {8'hA5, 8'h02, 8'h00, 8'h34};
    send_seq();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_wr_en", 32'(wr_en), 32'd0);
    check("mid_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_wr_data", 32'(wr_data), 32'd0);
    check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_nwrites", 32'(wq_addr.size()), 32'd0);
    reset = 1'b0;
    tx = {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAE};
    send_seq();
    wait_release(fall);
    check("mid_nwrites_after", 32'(wq_addr.size()), 32'd1);
    check_write("mid_w0", 0, 0, 16'hBEEF, hs_q[4]);
    check("mid_release", 32'(fall - hs_q[5]), 32'd5);
    check("mid_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
